// File: rtl/mult_share_sched.sv
// Round-robin front end for one shared combinational multiplier.
// Each operation takes three states: IDLE (grant), ISSUE (multiply), RESP (drain).
module mult_share_sched #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]      mul_a,
  output logic [WIDTH-1:0]      mul_b,
  input  logic [2*WIDTH-1:0]    mul_product,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [2*WIDTH-1:0]    resp_product,
  output logic [IDW-1:0]        resp_id,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  state_e               state_q, state_d;
  logic [IDW-1:0]       rr_ptr_q;
  logic [WIDTH-1:0]     mul_a_q, mul_b_q;
  logic [2*WIDTH-1:0]   resp_product_q;
  logic [IDW-1:0]       resp_id_q;
  logic                 resp_valid_q;

  logic                 found;
  logic [IDW-1:0]       gnt_id;
  logic [IDW-1:0]       nxt_ptr;
  logic                 accept;
  int                   idx;

  // Priority scan starting at rr_ptr, wrapping modulo NREQ (NREQ need not be a power of two).
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        gnt_id = IDW'(idx);
      end
    end
  end

  assign nxt_ptr = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          req_ready[gnt_id] = 1'b1;
          accept            = 1'b1;
          state_d           = ISSUE;
        end
      end
      ISSUE:   state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
      resp_product_q <= '0;
      resp_id_q      <= '0;
      resp_valid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mul_a_q   <= req_a[int'(gnt_id)*WIDTH +: WIDTH];
        mul_b_q   <= req_b[int'(gnt_id)*WIDTH +: WIDTH];
        resp_id_q <= gnt_id;
        rr_ptr_q  <= nxt_ptr;
      end
      if (state_q == ISSUE) begin
        resp_product_q <= mul_product;
        resp_valid_q   <= 1'b1;
      end else if (state_q == RESP && resp_ready) begin
        resp_valid_q <= 1'b0;
      end
    end
  end

  assign mul_a        = mul_a_q;
  assign mul_b        = mul_b_q;
  assign resp_product = resp_product_q;
  assign resp_id      = resp_id_q;
  assign resp_valid   = resp_valid_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_mult_share_sched.sv
// Directed bench for mult_share_sched; the shared multiplier is modelled inline.
module tb_mult_share_sched;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [WIDTH-1:0]      mul_a, mul_b;
  logic [2*WIDTH-1:0]    mul_product;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [2*WIDTH-1:0]    resp_product;
  logic [IDW-1:0]        resp_id;
  logic                  busy;

  logic [WIDTH-1:0] a_v [NREQ];
  logic [WIDTH-1:0] b_v [NREQ];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign req_a       = {a_v[3], a_v[2], a_v[1], a_v[0]};
  assign req_b       = {b_v[3], b_v[2], b_v[1], b_v[0]};
  assign mul_product = 16'(mul_a) * 16'(mul_b);

  mult_share_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_product(resp_product), .resp_id(resp_id),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge in IDLE with the requester already valid; ends at a negedge back in IDLE.
  task automatic do_op(input string tag, input int id, input logic [7:0] ea,
                       input logic [15:0] ep, input logic [3:0] v_issue);
    chk({tag, ".grant"}, 32'(req_ready), 32'(4'b1 << id));
    resp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid = v_issue;
    #1;
    chk({tag, ".issue_busy"}, 32'(busy), 1);
    chk({tag, ".issue_vld"}, 32'(resp_valid), 0);
    chk({tag, ".issue_rdy"}, 32'(req_ready), 0);
    chk({tag, ".mul_a"}, 32'(mul_a), 32'(ea));
    @(posedge clk); @(negedge clk);
    chk({tag, ".resp_vld"}, 32'(resp_valid), 1);
    chk({tag, ".resp_prod"}, 32'(resp_product), 32'(ep));
    chk({tag, ".resp_id"}, 32'(resp_id), 32'(id));
    chk({tag, ".resp_rdy"}, 32'(req_ready), 0);
    @(posedge clk); @(negedge clk);
    chk({tag, ".idle"}, 32'(busy), 0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; resp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin a_v[i] = '0; b_v[i] = '0; end
    #12;
    chk("rst.req_ready", 32'(req_ready), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.resp_valid", 32'(resp_valid), 0);
    chk("rst.mul_ab", {16'h0, mul_a, mul_b}, 0);
    chk("rst.resp", {14'h0, resp_id, resp_product}, 0);
    @(negedge clk); rst_n = 1'b1;

    // Single requester 2: 13*11 = 143
    @(negedge clk);
    a_v[2] = 8'd13; b_v[2] = 8'd11; req_valid = 4'b0100;
    #1 chk("single.grant", 32'(req_ready), 32'(4'b0100));
    @(posedge clk); @(negedge clk);
    req_valid = '0;
    chk("single.issue_vld", 32'(resp_valid), 0);
    chk("single.mul", {16'h0, mul_a, mul_b}, 32'h0D0B);
    @(posedge clk); @(negedge clk);
    chk("single.vld", 32'(resp_valid), 1);
    chk("single.prod", 32'(resp_product), 143);
    chk("single.id", 32'(resp_id), 2);
    resp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("single.drain", 32'(resp_valid), 0);

    // Reset so contention starts from rr_ptr = 0
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;

    // Full contention: a=i+1, b=i+3
    for (int i = 0; i < NREQ; i++) begin a_v[i] = 8'(i + 1); b_v[i] = 8'(i + 3); end
    req_valid = 4'b1111;
    #1;
    do_op("cont0", 0, 8'd1, 16'd3,  4'b1111);
    do_op("cont1", 1, 8'd2, 16'd8,  4'b1111);
    do_op("cont2", 2, 8'd3, 16'd15, 4'b1111);
    do_op("cont3", 3, 8'd4, 16'd24, 4'b1111);
    do_op("cont4", 0, 8'd1, 16'd3,  4'b0000);

    // Sparse: only 1 and 3 valid, pointer now at 1
    req_valid = 4'b1010; #1;
    do_op("sparse1", 1, 8'd2, 16'd8,  4'b1010);
    do_op("sparse3", 3, 8'd4, 16'd24, 4'b1010);
    do_op("sparse1b", 1, 8'd2, 16'd8, 4'b0000);

    // Maximum operands on requester 2
    a_v[2] = 8'd255; b_v[2] = 8'd255; req_valid = 4'b0100; #1;
    do_op("max", 2, 8'd255, 16'hFE01, 4'b0000);

    // Backpressure on requester 3: 7*9 = 63, others valid during RESP
    a_v[3] = 8'd7; b_v[3] = 8'd9; req_valid = 4'b1000; resp_ready = 1'b0;
    #1 chk("bp.grant", 32'(req_ready), 32'(4'b1000));
    @(posedge clk); @(negedge clk);
    req_valid = 4'b1111;
    @(posedge clk); @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      chk("bp.vld", 32'(resp_valid), 1);
      chk("bp.hold", {14'h0, resp_id, resp_product}, {14'h0, 2'd3, 16'd63});
      chk("bp.rdy", 32'(req_ready), 0);
      @(posedge clk); @(negedge clk);
    end
    resp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("bp.idle", 32'(busy), 0);
    chk("bp.drain", 32'(resp_valid), 0);
    chk("bp.next_grant", 32'(req_ready), 32'(4'b0001));

    // Reset during ISSUE
    @(posedge clk); @(negedge clk);
    chk("rmid.in_issue", 32'(busy), 1);
    rst_n = 1'b0; req_valid = '0;
    #1;
    chk("rmid.busy", 32'(busy), 0);
    chk("rmid.outs", {15'h0, resp_valid, mul_a, mul_b}, 0);
    chk("rmid.resp", {14'h0, resp_id, resp_product}, 0);
    chk("rmid.rdy", 32'(req_ready), 0);
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rmid.no_resp", {30'h0, busy, resp_valid}, 0);
    end
    req_valid = 4'b1111; #1;
    chk("rmid.grant0", 32'(req_ready), 32'(4'b0001));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end

endmodule
